// File: rtl/multicyc_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicyc_ctrl_if
// Control bus between the multicycle MIPS control FSM and its datapath/memory.
//
// Signals:
//   iOpcode     6  IR[31:26] from the instruction register
//   iZero       1  ALU zero flag
//   iMemReady   1  unified memory has completed the current access
//   oPcWe       1  PC write enable (branch condition already applied)
//   oIorD       1  memory address select: 0 = PC, 1 = ALUOut
//   oMemRd      1  memory read request
//   oMemWr      1  memory write request
//   oIrWe       1  instruction register write
//   oMemToReg   1  writeback source: 1 = MDR, 0 = ALUOut
//   oRegDst     1  destination register: 1 = rd, 0 = rt
//   oRegWe      1  register file write
//   oAluSrcA    1  ALU A: 0 = PC, 1 = rs
//   oAluSrcB    2  ALU B: 00 = rt, 01 = 4, 10 = simm, 11 = simm << 2
//   oAluOp      2  00 = add, 01 = sub, 10 = funct, 11 = opcode
//   oPcSrc      2  00 = ALU result, 01 = ALUOut, 10 = jump target
//   oIllegal    1  one-cycle pulse on an unsupported opcode
//   oMemTimeout 1  one-cycle pulse when a memory wait times out
//   oState      4  current FSM state, for debug
//
// Modports: master = control FSM, slave = datapath/memory side.
// ----------------------------------------------------------------------------
interface multicyc_ctrl_if;
    logic [5:0] iOpcode;
    logic       iZero;
    logic       iMemReady;
    logic       oPcWe;
    logic       oIorD;
    logic       oMemRd;
    logic       oMemWr;
    logic       oIrWe;
    logic       oMemToReg;
    logic       oRegDst;
    logic       oRegWe;
    logic       oAluSrcA;
    logic [1:0] oAluSrcB;
    logic [1:0] oAluOp;
    logic [1:0] oPcSrc;
    logic       oIllegal;
    logic       oMemTimeout;
    logic [3:0] oState;

    modport master (
        input  iOpcode, iZero, iMemReady,
        output oPcWe, oIorD, oMemRd, oMemWr, oIrWe, oMemToReg, oRegDst, oRegWe,
               oAluSrcA, oAluSrcB, oAluOp, oPcSrc, oIllegal, oMemTimeout, oState
    );

    modport slave (
        output iOpcode, iZero, iMemReady,
        input  oPcWe, oIorD, oMemRd, oMemWr, oIrWe, oMemToReg, oRegDst, oRegWe,
               oAluSrcA, oAluSrcB, oAluOp, oPcSrc, oIllegal, oMemTimeout, oState
    );
endinterface

// File: rtl/multicyc_ctrl.sv
// ----------------------------------------------------------------------------
// multicyc_ctrl
// Main control FSM of the multicycle MIPS core. Sequences the shared ALU, the
// unified instruction/data memory port and the register file through fetch,
// decode, execute, memory and writeback steps. Outputs are Moore decodes of
// the registered state; only PC/IR/memory enables are qualified by iMemReady
// and iZero. A wait counter bounds every memory wait.
//
// Ports:
//   iClk     in   clock, rising edge
//   iRst_n   in   asynchronous active-low reset
//   io_ctrl  master modport of multicyc_ctrl_if (opcode/zero/ready in,
//            all datapath controls, pulses and debug state out)
//
// Parameters:
//   MEM_WAIT_MAX  maximum counted wait cycles before a memory timeout
//
// Optional feature macro: MULTICYC_CTRL_JAL_EN
//   Defined   : opcode 000011 (jal) goes to state 12, writes PC and links r31.
//   Undefined : 000011 is illegal and state 12 is unreachable.
// ----------------------------------------------------------------------------
module multicyc_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic           iClk,
    input  logic           iRst_n,
    multicyc_ctrl_if.master io_ctrl
);

    localparam int unsigned CntW = $clog2(MEM_WAIT_MAX + 1) < 1 ? 1 : $clog2(MEM_WAIT_MAX + 1);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
`ifdef MULTICYC_CTRL_JAL_EN
    localparam logic [5:0] OpJal   = 6'b000011;
`endif

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StIExec  = 4'd10,
        StIwb    = 4'd11,
        StJal    = 4'd12
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CntW-1:0]   r_wait_cnt;
    logic [CntW-1:0]   w_wait_cnt_next;

    logic              w_is_wait_state;
    logic              w_timeout;

    logic              w_pc_we;
    logic              w_ior_d;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic              w_ir_we;
    logic              w_mem_to_reg;
    logic              w_reg_dst;
    logic              w_reg_we;
    logic              w_alu_src_a;
    logic [1:0]        w_alu_src_b;
    logic [1:0]        w_alu_op;
    logic [1:0]        w_pc_src;
    logic              w_illegal;

    // Only these three states stall on the memory handshake.
    assign w_is_wait_state = (r_state == StFetch) || (r_state == StMemRd) ||
                             (r_state == StMemWr);

    // Ready on the expiry cycle still wins: the access completed in time.
    assign w_timeout = w_is_wait_state && !io_ctrl.iMemReady &&
                       (r_wait_cnt == CntW'(MEM_WAIT_MAX));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state    <= StFetch;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if ((w_state_next != r_state) || w_timeout) begin
            w_wait_cnt_next = '0;
        end else if (w_is_wait_state && !io_ctrl.iMemReady) begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_we      = 1'b0;
        w_ior_d      = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_ir_we      = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_we     = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;
        w_illegal    = 1'b0;

        unique case (r_state)
            StFetch: begin
                // ALU computes PC+4 while the instruction is read.
                w_mem_rd    = !w_timeout;
                w_alu_src_b = 2'b01;
                if (io_ctrl.iMemReady) begin
                    w_ir_we      = 1'b1;
                    w_pc_we      = 1'b1;
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                // Branch target is precomputed into ALUOut here.
                w_alu_src_b = 2'b11;
                case (io_ctrl.iOpcode)
                    OpRtype:                       w_state_next = StExec;
                    OpLw, OpSw:                    w_state_next = StMemAdr;
                    OpBeq, OpBne:                  w_state_next = StBranch;
                    OpJ:                           w_state_next = StJump;
                    OpAddi, OpAndi, OpOri, OpSlti: w_state_next = StIExec;
`ifdef MULTICYC_CTRL_JAL_EN
                    OpJal:                         w_state_next = StJal;
`endif
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_state_next = (io_ctrl.iOpcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                w_mem_rd = !w_timeout;
                w_ior_d  = 1'b1;
                if (io_ctrl.iMemReady) begin
                    w_state_next = StMemWb;
                end
            end
            StMemWb: begin
                w_reg_we     = 1'b1;
                w_mem_to_reg = 1'b1;
                w_state_next = StFetch;
            end
            StMemWr: begin
                w_mem_wr = !w_timeout;
                w_ior_d  = 1'b1;
                if (io_ctrl.iMemReady) begin
                    w_state_next = StFetch;
                end
            end
            StExec: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b10;
                w_state_next = StRwb;
            end
            StRwb: begin
                w_reg_we     = 1'b1;
                w_reg_dst    = 1'b1;
                w_state_next = StFetch;
            end
            StBranch: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b01;
                w_pc_src     = 2'b01;
                w_pc_we      = (io_ctrl.iOpcode == OpBne) ? !io_ctrl.iZero : io_ctrl.iZero;
                w_state_next = StFetch;
            end
            StJump: begin
                w_pc_src     = 2'b10;
                w_pc_we      = 1'b1;
                w_state_next = StFetch;
            end
            StIExec: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_alu_op     = 2'b11;
                w_state_next = StIwb;
            end
            StIwb: begin
                w_reg_we     = 1'b1;
                w_state_next = StFetch;
            end
`ifdef MULTICYC_CTRL_JAL_EN
            StJal: begin
                // PC already holds PC+4; an external mux keyed on oState==12
                // routes it to r31 as the link value.
                w_pc_src     = 2'b10;
                w_pc_we      = 1'b1;
                w_reg_we     = 1'b1;
                w_reg_dst    = 1'b1;
                w_state_next = StFetch;
            end
`endif
            default: begin
                w_state_next = StFetch;
            end
        endcase

        if (w_timeout) begin
            // Abort the access: nothing is written this cycle.
            w_pc_we      = 1'b0;
            w_ir_we      = 1'b0;
            w_mem_wr     = 1'b0;
            w_mem_rd     = 1'b0;
            w_state_next = StFetch;
        end
    end

    assign io_ctrl.oPcWe       = w_pc_we;
    assign io_ctrl.oIorD       = w_ior_d;
    assign io_ctrl.oMemRd      = w_mem_rd;
    assign io_ctrl.oMemWr      = w_mem_wr;
    assign io_ctrl.oIrWe       = w_ir_we;
    assign io_ctrl.oMemToReg   = w_mem_to_reg;
    assign io_ctrl.oRegDst     = w_reg_dst;
    assign io_ctrl.oRegWe      = w_reg_we;
    assign io_ctrl.oAluSrcA    = w_alu_src_a;
    assign io_ctrl.oAluSrcB    = w_alu_src_b;
    assign io_ctrl.oAluOp      = w_alu_op;
    assign io_ctrl.oPcSrc      = w_pc_src;
    assign io_ctrl.oIllegal    = w_illegal;
    assign io_ctrl.oMemTimeout = w_timeout;
    assign io_ctrl.oState      = r_state;

endmodule

// File: tb/tb_multicyc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicyc_ctrl
// Self-checking bench for multicyc_ctrl. An instruction-level model expands
// each instruction (opcode, memory delays, zero flag) into the expected state
// walk and per-cycle control values; directed cases first, then random ones.
// ----------------------------------------------------------------------------
module tb_multicyc_ctrl;

    localparam int unsigned WaitMax = 15;

    typedef struct packed {
        logic       pc_we;
        logic       ior_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_we;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic       timeout;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multicyc_ctrl_if bus ();

    multicyc_ctrl #(
        .MEM_WAIT_MAX(WaitMax)
    ) u_dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .io_ctrl(bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return 1'b1;
`ifdef MULTICYC_CTRL_JAL_EN
            6'b000011: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Control values the specification lists for each state.
    function automatic ctl_t expect_ctl(input int st, input bit rdy, input bit zero,
                                        input logic [5:0] op, input bit to);
        ctl_t c;
        c = '0;
        c.timeout = to;
        case (st)
            0: begin
                c.mem_rd    = !to;
                c.alu_src_b = 2'b01;
                c.ir_we     = rdy && !to;
                c.pc_we     = rdy && !to;
            end
            1: begin
                c.alu_src_b = 2'b11;
                c.illegal   = !is_legal(op);
            end
            2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            3: begin c.mem_rd = !to; c.ior_d = 1'b1; end
            4: begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
            5: begin c.mem_wr = !to; c.ior_d = 1'b1; end
            6: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            7: begin c.reg_we = 1'b1; c.reg_dst = 1'b1; end
            8: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.pc_we     = (op == 6'b000101) ? !zero : zero;
            end
            9: begin c.pc_src = 2'b10; c.pc_we = 1'b1; end
            10: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            11: begin c.reg_we = 1'b1; end
            12: begin c.pc_src = 2'b10; c.pc_we = 1'b1; c.reg_we = 1'b1; c.reg_dst = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t observed_ctl();
        ctl_t c;
        c.pc_we      = bus.oPcWe;
        c.ior_d      = bus.oIorD;
        c.mem_rd     = bus.oMemRd;
        c.mem_wr     = bus.oMemWr;
        c.ir_we      = bus.oIrWe;
        c.mem_to_reg = bus.oMemToReg;
        c.reg_dst    = bus.oRegDst;
        c.reg_we     = bus.oRegWe;
        c.alu_src_a  = bus.oAluSrcA;
        c.alu_src_b  = bus.oAluSrcB;
        c.alu_op     = bus.oAluOp;
        c.pc_src     = bus.oPcSrc;
        c.illegal    = bus.oIllegal;
        c.timeout    = bus.oMemTimeout;
        return c;
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    // Called just after a rising edge: drive, settle, check, advance one cycle.
    task automatic do_cycle(input int st, input bit rdy, input bit zero,
                            input logic [5:0] op, input bit to);
        bus.iMemReady = rdy;
        bus.iZero     = zero;
        #1;
        check_val($sformatf("state op%02h", op), 32'(bus.oState), 32'(st));
        check_val($sformatf("ctl st%0d op%02h rdy%0d", st, op, rdy),
                  32'(observed_ctl()), 32'(expect_ctl(st, rdy, zero, op, to)));
        @(posedge clk);
        #1;
    endtask

    // Memory wait of d not-ready cycles; beyond the bound it ends in a timeout.
    task automatic wait_phase(input int st, input int d, input logic [5:0] op, output bit to);
        to = 1'b0;
        if (d > int'(WaitMax)) begin
            for (int i = 0; i < int'(WaitMax); i++) do_cycle(st, 1'b0, rbit(), op, 1'b0);
            do_cycle(st, 1'b0, rbit(), op, 1'b1);
            to = 1'b1;
        end else begin
            for (int i = 0; i < d; i++) do_cycle(st, 1'b0, rbit(), op, 1'b0);
            do_cycle(st, 1'b1, rbit(), op, 1'b0);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int df, input int dm, input bit zero);
        bit to;
        int d;
        bus.iOpcode = op;
        d = df;
        // A timed-out fetch left the PC alone, so the same fetch repeats.
        do begin
            wait_phase(0, d, op, to);
            d = 0;
        end while (to);
        do_cycle(1, rbit(), rbit(), op, 1'b0);
        if (!is_legal(op)) return;
        case (op)
            6'b000000: begin
                do_cycle(6, rbit(), rbit(), op, 1'b0);
                do_cycle(7, rbit(), rbit(), op, 1'b0);
            end
            6'b100011: begin
                do_cycle(2, rbit(), rbit(), op, 1'b0);
                wait_phase(3, dm, op, to);
                if (!to) do_cycle(4, rbit(), rbit(), op, 1'b0);
            end
            6'b101011: begin
                do_cycle(2, rbit(), rbit(), op, 1'b0);
                wait_phase(5, dm, op, to);
            end
            6'b000100, 6'b000101: do_cycle(8, rbit(), zero, op, 1'b0);
            6'b000010: do_cycle(9, rbit(), rbit(), op, 1'b0);
            6'b000011: do_cycle(12, rbit(), rbit(), op, 1'b0);
            default: begin
                do_cycle(10, rbit(), rbit(), op, 1'b0);
                do_cycle(11, rbit(), rbit(), op, 1'b0);
            end
        endcase
    endtask

    logic [5:0] op_tbl [12];

    initial begin
        op_tbl = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                   6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000011, 6'b111111};
        rst_n         = 1'b0;
        bus.iOpcode   = 6'b000000;
        bus.iZero     = 1'b0;
        bus.iMemReady = 1'b0;

        // Reset values with memory not ready.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst state", 32'(bus.oState), 32'd0);
        check_val("rst ctl", 32'(observed_ctl()), 32'(expect_ctl(0, 1'b0, 1'b0, 6'd0, 1'b0)));
        rst_n = 1'b1;

        // Directed cases.
        run_instr(6'b000000, 3, 0, 1'b0);
        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 0, 2, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1);
        run_instr(6'b000101, 0, 0, 1'b1);
        run_instr(6'b000100, 1, 0, 1'b0);
        run_instr(6'b000101, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b000011, 0, 0, 1'b0);
        run_instr(6'b001000, 16, 0, 1'b0);
        run_instr(6'b001101, 15, 0, 1'b0);
        run_instr(6'b100011, 0, 15, 1'b0);
        run_instr(6'b100011, 0, 20, 1'b0);
        run_instr(6'b101011, 1, 17, 1'b0);
        run_instr(6'b101011, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);

        // Reset mid-store: state must drop to FETCH at once, write withdrawn.
        bus.iOpcode = 6'b101011;
        do_cycle(0, 1'b1, 1'b0, 6'b101011, 1'b0);
        do_cycle(1, 1'b0, 1'b0, 6'b101011, 1'b0);
        do_cycle(2, 1'b0, 1'b0, 6'b101011, 1'b0);
        do_cycle(5, 1'b0, 1'b0, 6'b101011, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("async rst state", 32'(bus.oState), 32'd0);
        check_val("async rst memwr", 32'(bus.oMemWr), 32'd0);
        @(posedge clk);
        #1;
        bus.iMemReady = 1'b1;
        #1;
        check_val("rst hold state", 32'(bus.oState), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post rst state", 32'(bus.oState), 32'd1);
        do_cycle(1, 1'b0, 1'b0, 6'b101011, 1'b0);
        do_cycle(2, 1'b0, 1'b0, 6'b101011, 1'b0);
        do_cycle(5, 1'b1, 1'b0, 6'b101011, 1'b0);

        // Random instruction stream.
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int df;
            int dm;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : op_tbl[$urandom_range(0, 11)];
            df = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 18))
                                              : int'($urandom_range(0, 3));
            dm = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 18))
                                              : int'($urandom_range(0, 3));
            run_instr(op, df, dm, rbit());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicyc_ctrl.md
Name: multicyc_ctrl

Overview:
Main control FSM for the multicycle MIPS core. It sequences one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback steps. It decodes iOpcode, waits on memory through a ready handshake, and drives every datapath mux and write enable. Moore outputs come from the registered state; only the PC/IR/memory enables are qualified by iMemReady and iZero.

Parameters:
- MEM_WAIT_MAX, 15: upper bound on cycles spent waiting for iMemReady. On expiry: pulse oMemTimeout, return to S_FETCH.

Ports:
- iClk  in  1  clock, rising edge
- iRst_n  in  1  asynchronous active-low reset
- iOpcode  in  6  IR[31:26]
- iZero  in  1  ALU zero flag
- iMemReady  in  1  memory has completed the current access
- oPcWe  out  1  PC write enable (already includes the branch condition)
- oIorD  out  1  0 = address from PC, 1 = address from ALUOut
- oMemRd  out  1  memory read request
- oMemWr  out  1  memory write request
- oIrWe  out  1  instruction register write
- oMemToReg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- oRegDst  out  1  1 = rd, 0 = rt
- oRegWe  out  1  register file write
- oAluSrcA  out  1  0 = PC, 1 = rs
- oAluSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- oAluOp  out  2  00 = add, 01 = sub, 10 = use funct, 11 = use opcode (I-type logical/slt)
- oPcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- oIllegal  out  1  one-cycle pulse when an opcode is unsupported
- oMemTimeout  out  1  one-cycle pulse when a memory wait times out
- oState  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JAL=12.
- Reset: state goes to FETCH and the wait counter to 0, both asynchronously.
- Output values in reset, given iMemReady=0: oMemRd=1, oIorD=0, oAluSrcA=0, oAluSrcB=01, oAluOp=00, oPcSrc=00. All other enables are 0, all pulses are 0, and oState=0.
- Any output not listed for a state is 0.
- FETCH: oMemRd=1, oIorD=0, oAluSrcA=0, oAluSrcB=01, oAluOp=00, oPcSrc=00.
  - oIrWe and oPcWe are asserted only while iMemReady=1.
  - Stay in FETCH while iMemReady=0; go to DECODE when iMemReady=1.
- DECODE: oAluSrcA=0, oAluSrcB=11, oAluOp=00 (branch target goes to ALUOut).
  - Next state by opcode:
    - 000000 (R-type) -> EXEC
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000100 (beq) and 000101 (bne) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000, 001100, 001101, 001010 (addi, andi, ori, slti) -> IEXEC
    - anything else -> FETCH, with oIllegal pulsed during this DECODE cycle
- MEMADR: oAluSrcA=1, oAluSrcB=10, oAluOp=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: oMemRd=1, oIorD=1. Wait until iMemReady=1, then go to MEMWB.
- MEMWB: oRegWe=1, oMemToReg=1, oRegDst=0. Next state FETCH.
- MEMWR: oMemWr=1, oIorD=1. Wait until iMemReady=1, then go to FETCH.
- EXEC: oAluSrcA=1, oAluSrcB=00, oAluOp=10. Next state RWB.
- RWB: oRegWe=1, oRegDst=1, oMemToReg=0. Next state FETCH.
- BRANCH: oAluSrcA=1, oAluSrcB=00, oAluOp=01, oPcSrc=01.
  - oPcWe = iZero for beq, ~iZero for bne. Next state FETCH.
- JUMP: oPcSrc=10, oPcWe=1. Next state FETCH.
- IEXEC: oAluSrcA=1, oAluSrcB=10, oAluOp=11. Next state IWB.
- IWB: oRegWe=1, oRegDst=0, oMemToReg=0. Next state FETCH.
- Wait counter:
  - Counts cycles spent in FETCH/MEMRD/MEMWR with iMemReady=0, and clears on any state change.
  - When the count reaches MEM_WAIT_MAX with iMemReady still 0: pulse oMemTimeout, deassert all enables that cycle, and go to FETCH.
  - A timeout in FETCH restarts the same fetch, because the PC was not written.
- iMemReady is ignored in states that do not wait.
- Reset asserted mid-instruction aborts it immediately. No partial write completes after reset is released.
- Cycle counts with memory ready immediately: R-type/I-type/lw = 4/4/5, sw = 4, branch/jump = 3.

Optional Feature:
- MULTICYC_CTRL_JAL_EN.
  - Defined: opcode 000011 goes from DECODE to JAL. JAL drives oPcSrc=10, oPcWe=1, oRegWe=1 and a link write of PC+4 (already in PC) to register 31. oRegDst=1 and oMemToReg=0 take the link path through an external r31 mux, selected by oState==12. Next state FETCH.
  - Undefined: 000011 is illegal, and state 12 is unreachable.

Test Plan:
- Reset low, then high with iMemReady=0 for 3 cycles, then 1 -> oState stays 0 with oPcWe=0; on the ready cycle oIrWe=oPcWe=1; the next cycle is DECODE.
- R-type (000000), ready always 1 -> states 0,1,6,7,0; oRegWe=1 and oRegDst=1 only in state 7.
- lw (100011) with MEMRD ready delayed 2 cycles -> states 0,1,2,3,3,3,4,0; oIorD=1 throughout MEMRD; oMemToReg=1 in MEMWB.
- beq with iZero=1, then bne with iZero=1 -> oPcWe=1 in BRANCH for beq, oPcWe=0 for bne.
- Opcode 111111 -> oIllegal high exactly one cycle in DECODE, then FETCH; no write enable asserted.
- FETCH with iMemReady held 0 -> oMemTimeout pulses after MEM_WAIT_MAX=15 wait cycles; state remains FETCH; no PC write.
